vga_timing_gen: RTL and testbench

Pixel timing generator for the 640x480@60 Hz VGA display path. Divides the system clock into a pixel-enable tick and runs horizontal/vertical scan counters. Drives `x`, `y` and `video_on` to every layer renderer (platform map, sprites, background). Provides sync outputs delayed to match the renderers' synchronous-ROM latency, and a once-per-frame pulse for game-state update.

---
 rtl/vga_timing_gen_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants: default 640x480@60 mode, derived totals and sync windows.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_SYNC_DLY = 2;

  localparam int unsigned DEF_H_DISP = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;

  localparam int unsigned DEF_V_DISP = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows are inclusive on both ends.
  localparam int unsigned H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC - 1;
  localparam int unsigned V_SYNC_START = DEF_V_DISP + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC - 1;

  // True while a scan count sits inside an inclusive sync window.
  function automatic logic in_window(logic [COORD_W-1:0] cnt, int unsigned lo, int unsigned hi);
    return (cnt >= COORD_W'(lo)) && (cnt <= COORD_W'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle fanned out from the generator to the layer renderers and the pin mux.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic               p_tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               video_on;
  logic               hsync;
  logic               vsync;
  logic               hsync_d;
  logic               vsync_d;
  logic               video_on_d;
  logic               frame_start;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, hsync_d, vsync_d, video_on_d, frame_start
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, hsync_d, vsync_d, video_on_d, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-latency shift register with a loadable reset value; Depth of 0 is a wire.
module sync_delay_line #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] rst_val,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  // At least one stage is always declared so Depth=0 still elaborates; it is then unused.
  localparam int unsigned RegD = (Depth == 0) ? 1 : Depth;
  localparam int unsigned Last = RegD - 1;

  logic [RegD-1:0][Width-1:0] pipe_q;

  // Shift every clock; reset flushes all stages to the idle value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= {RegD{rst_val}};
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(RegD); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = (Depth == 0) ? din : pipe_q[Last];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: clock divider, scan counters, registered syncs and aligned delayed syncs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_DISP   = DEF_H_DISP,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_DISP   = DEF_V_DISP,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned SYNC_DLY = DEF_SYNC_DLY
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned HTotal     = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_DISP + H_FP;
  localparam int unsigned HSyncEnd   = H_DISP + H_FP + H_SYNC - 1;
  localparam int unsigned VSyncStart = V_DISP + V_FP;
  localparam int unsigned VSyncEnd   = V_DISP + V_FP + V_SYNC - 1;
  localparam int unsigned DivW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0]    div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               hsync_q, vsync_q;
  logic               p_tick, h_wrap, v_wrap, video_on;
  logic [2:0]         dly_out;

  // Next-state for divider and scan counters; counters move only on pixel ticks.
  always_comb begin
    p_tick    = (div_cnt_q == DivW'(CLK_DIV - 1));
    h_wrap    = (h_cnt_q == COORD_W'(HTotal - 1));
    v_wrap    = (v_cnt_q == COORD_W'(VTotal - 1));
    div_cnt_d = p_tick ? '0 : div_cnt_q + DivW'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (p_tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + COORD_W'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + COORD_W'(1);
      end
    end
  end

  // State registers; syncs are decoded from the current counts so they lag by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= ~in_window(h_cnt_q, HSyncStart, HSyncEnd);
      vsync_q   <= ~in_window(v_cnt_q, VSyncStart, VSyncEnd);
    end
  end

  assign video_on = (h_cnt_q < COORD_W'(H_DISP)) && (v_cnt_q < COORD_W'(V_DISP));

  // Matches the renderers' ROM latency; idles as syncs high, video blanked.
  sync_delay_line #(
    .Width (3),
    .Depth (SYNC_DLY)
  ) u_sync_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (3'b110),
    .din     ({hsync_q, vsync_q, video_on}),
    .dout    (dly_out)
  );

  assign vga.p_tick      = p_tick;
  assign vga.x           = h_cnt_q;
  assign vga.y           = v_cnt_q;
  assign vga.video_on    = video_on;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.hsync_d     = dly_out[2];
  assign vga.vsync_d     = dly_out[1];
  assign vga.video_on_d  = dly_out[0];
  assign vga.frame_start = p_tick && h_wrap && v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two shrunk-mode instances (div 4 / delay 2 and div 1 / delay 0).
module tb_vga_timing_gen;

  localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HD + HF + HS + HB;  // 15
  localparam int unsigned VT = VD + VF + VS + VB;  // 8
  localparam int unsigned RST_POINT = 1365;        // third frame of A, x=11 y=6

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       hsd;
    logic       vsd;
    logic       vond;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad = 0;

  int unsigned n_cnt = 0;
  bit          started = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  vga_timing_gen #(
    .CLK_DIV (4), .H_DISP (HD), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_DISP (VD), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .SYNC_DLY (2)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_a)
  );

  vga_timing_gen #(
    .CLK_DIV (1), .H_DISP (HD), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_DISP (VD), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .SYNC_DLY (0)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixel index reached n clocks after reset release.
  function automatic int unsigned pix(int unsigned n, int unsigned div);
    return (n / div) % (HT * VT);
  endfunction

  function automatic logic von_at(int unsigned n, int unsigned div);
    int unsigned p = pix(n, div);
    return ((p % HT) < HD) && ((p / HT) < VD);
  endfunction

  function automatic logic hs_at(int unsigned n, int unsigned div);
    int unsigned x;
    if (n == 0) return 1'b1;
    x = pix(n - 1, div) % HT;
    return !((x >= HD + HF) && (x <= HD + HF + HS - 1));
  endfunction

  function automatic logic vs_at(int unsigned n, int unsigned div);
    int unsigned y;
    if (n == 0) return 1'b1;
    y = pix(n - 1, div) / HT;
    return !((y >= VD + VF) && (y <= VD + VF + VS - 1));
  endfunction

  function automatic exp_t model(int unsigned n, int unsigned div, int unsigned dly);
    exp_t        e;
    int unsigned p = pix(n, div);
    e.pt   = (n % div) == (div - 1);
    e.x    = 10'(p % HT);
    e.y    = 10'(p / HT);
    e.von  = von_at(n, div);
    e.hs   = hs_at(n, div);
    e.vs   = vs_at(n, div);
    e.hsd  = (n >= dly) ? hs_at(n - dly, div) : 1'b1;
    e.vsd  = (n >= dly) ? vs_at(n - dly, div) : 1'b1;
    e.vond = (n >= dly) ? von_at(n - dly, div) : 1'b0;
    e.fs   = e.pt && (p == HT * VT - 1);
    return e;
  endfunction

  // Expected state for each edge is queued as the edge happens.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n_cnt   = 0;
        started = 1;
      end else if (started) begin
        n_cnt++;
      end
      if (started) begin
        q_a.push_back(model(n_cnt, 4, 2));
        q_b.push_back(model(n_cnt, 1, 0));
      end
    end
  end

  // Compare on the falling edge, plus frame_start spacing within one reset epoch.
  initial begin
    exp_t        ea, eb;
    int unsigned last_a = 0, last_b = 0;
    bit          valid_a = 0, valid_b = 0;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0 && q_b.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check_eq("a_p_tick", vga_a.p_tick, ea.pt);
        check_eq("a_x", vga_a.x, ea.x);
        check_eq("a_y", vga_a.y, ea.y);
        check_eq("a_video_on", vga_a.video_on, ea.von);
        check_eq("a_hsync", vga_a.hsync, ea.hs);
        check_eq("a_vsync", vga_a.vsync, ea.vs);
        check_eq("a_hsync_d", vga_a.hsync_d, ea.hsd);
        check_eq("a_vsync_d", vga_a.vsync_d, ea.vsd);
        check_eq("a_video_on_d", vga_a.video_on_d, ea.vond);
        check_eq("a_frame_start", vga_a.frame_start, ea.fs);
        check_eq("b_p_tick", vga_b.p_tick, eb.pt);
        check_eq("b_x", vga_b.x, eb.x);
        check_eq("b_y", vga_b.y, eb.y);
        check_eq("b_video_on", vga_b.video_on, eb.von);
        check_eq("b_hsync", vga_b.hsync, eb.hs);
        check_eq("b_vsync", vga_b.vsync, eb.vs);
        check_eq("b_hsync_d", vga_b.hsync_d, eb.hsd);
        check_eq("b_vsync_d", vga_b.vsync_d, eb.vsd);
        check_eq("b_video_on_d", vga_b.video_on_d, eb.vond);
        check_eq("b_frame_start", vga_b.frame_start, eb.fs);
        if (n_cnt == 0) begin
          valid_a = 0;
          valid_b = 0;
        end
        if (vga_a.frame_start === 1'b1) begin
          if (valid_a) check_eq("a_frame_period", n_cnt - last_a, HT * VT * 4);
          last_a  = n_cnt;
          valid_a = 1;
        end
        if (vga_b.frame_start === 1'b1) begin
          if (valid_b) check_eq("b_frame_period", n_cnt - last_b, HT * VT);
          last_b  = n_cnt;
          valid_b = 1;
        end
      end
    end
  end

  // Stimulus: reset, run into the third frame, reset inside both sync pulses, run again.
  initial begin
    int guard = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    while (n_cnt != RST_POINT && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check_eq("reach_reset_point", n_cnt, RST_POINT);
    check_eq("pre_rst_x", vga_a.x, 11);
    check_eq("pre_rst_y", vga_a.y, 6);
    check_eq("pre_rst_hsync", vga_a.hsync, 0);
    check_eq("pre_rst_vsync", vga_a.vsync, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_x", vga_a.x, 0);
    check_eq("rst_y", vga_a.y, 0);
    check_eq("rst_p_tick", vga_a.p_tick, 0);
    check_eq("rst_video_on", vga_a.video_on, 1);
    check_eq("rst_hsync", vga_a.hsync, 1);
    check_eq("rst_vsync", vga_a.vsync, 1);
    check_eq("rst_hsync_d", vga_a.hsync_d, 1);
    check_eq("rst_vsync_d", vga_a.vsync_d, 1);
    check_eq("rst_video_on_d", vga_a.video_on_d, 0);
    check_eq("rst_frame_start", vga_a.frame_start, 0);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
